fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_buffer.sv | 69 ++++++
 rtl/fetch_unit.sv | 118 +++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and sizing for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PC_STEP   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Low two address bits are never honoured on a fetch target.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, redirect input and datapath handoff.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_ack;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                inst_valid;
    logic [INSTR_W-1:0]  instruction;
    logic [ADDR_W-1:0]   inst_pc;
    logic                inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, instruction, inst_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, instruction, inst_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry shifting FIFO of {pc, instruction}; head is always slot 0 so it leaves a flop directly.
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output fetch_entry_t     head_o
);

    fetch_entry_t     entries_q [BUF_DEPTH];
    fetch_entry_t     entries_d [BUF_DEPTH];
    logic [CNT_W-1:0] count_q, count_d, fill_idx;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_pop   = pop_i && !empty_q;
    assign do_push  = push_i && (!full_q || do_pop);
    assign fill_idx = count_q - CNT_W'(do_pop);

    // Shift on pop, then write the new word into the first free slot.
    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            if (do_pop) begin
                for (int unsigned i = 0; i < BUF_DEPTH - 1; i++) begin
                    entries_d[i] = entries_q[i+1];
                end
            end
            if (do_push) begin
                for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                    if (CNT_W'(i) == fill_idx) begin
                        entries_d[i] = push_data_i;
                    end
                end
            end
            count_d = fill_idx + CNT_W'(do_push);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '{default: '0};
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
            full_q    <= (count_d == CNT_W'(BUF_DEPTH));
            empty_q   <= (count_d == '0);
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;
    assign head_o  = entries_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request feeding a two-entry buffer.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky align_fault output for misaligned redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master fetch_if
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic         align_fault
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] redirect_tgt;

    logic              buf_push, buf_pop, buf_full, buf_empty;
    logic [CNT_W-1:0]  buf_count;
    logic [CNT_W:0]    cnt_next;
    fetch_entry_t      push_entry, head_entry;

    assign redirect_tgt = word_align(fetch_if.redirect_pc);
    assign buf_pop      = !buf_empty && fetch_if.inst_ready && !fetch_if.redirect;
    assign buf_push     = (state_q == ST_REQ) && fetch_if.imem_ack && !fetch_if.redirect;
    assign cnt_next     = {1'b0, buf_count} + (CNT_W+1)'(buf_push) - (CNT_W+1)'(buf_pop);
    assign push_entry   = '{pc: fetch_pc_q, instr: fetch_if.imem_rdata};

    fetch_buffer u_buffer (
        .clk         (clk),
        .rst_n       (reset),
        .flush_i     (fetch_if.redirect),
        .push_i      (buf_push),
        .push_data_i (push_entry),
        .pop_i       (buf_pop),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count),
        .head_o      (head_entry)
    );

    // A new request is issued whenever the buffer will have room once the current ack lands.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_if.redirect) begin
                    state_d    = ST_REQ;
                    fetch_pc_d = redirect_tgt;
                end else if (!buf_full || buf_pop) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (fetch_if.redirect) begin
                    fetch_pc_d = redirect_tgt;
                    state_d    = fetch_if.imem_ack ? ST_REQ : ST_DROP;
                end else if (fetch_if.imem_ack) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
                    state_d    = (cnt_next < (CNT_W+1)'(BUF_DEPTH)) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (fetch_if.redirect) begin
                    fetch_pc_d = redirect_tgt;
                end
                if (fetch_if.imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        imem_req_d  = (state_d != ST_IDLE);
        // The stale request keeps its original address until memory accepts it.
        imem_addr_d = (state_d == ST_DROP) ? imem_addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_fault_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            align_fault_q <= 1'b0;
        end else if (fetch_if.redirect && (fetch_if.redirect_pc[1:0] != 2'b00)) begin
            align_fault_q <= 1'b1;
        end
    end

    assign align_fault = align_fault_q;
`endif

    assign fetch_if.imem_req    = imem_req_q;
    assign fetch_if.imem_addr   = imem_addr_q;
    assign fetch_if.inst_valid  = !buf_empty;
    assign fetch_if.instruction = head_entry.instr;
    assign fetch_if.inst_pc     = head_entry.pc;

endmodule
